// File: rtl/sparc_rr_sel4.sv
// Registered 4-way round-robin arbiter driving one-cold, active-low decoded
// selects for a 4:1 datapath mux. Supports bounded multi-cycle grant hold.
module sparc_rr_sel4 #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       hold,
  input  logic       stall,
  output logic       sel0_l,
  output logic       sel1_l,
  output logic       sel2_l,
  output logic       sel3_l,
  output logic       gnt_vld,
  output logic [1:0] gnt_id
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  logic [3:0]    sel_l_q, sel_l_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic          others_req;
  logic          hold_ok;
  logic          found;
  logic [1:0]    winner;
  logic [1:0]    cand;

  // gnt_id doubles as the priority pointer: the last grantee is scanned last.
  always_comb begin
    others_req = |(req & ~(4'b0001 << gnt_id_q));
    hold_ok    = gnt_vld_q && hold && req[gnt_id_q] &&
                 ((hold_cnt_q < CNT_MAX) || !others_req);
  end

  always_comb begin
    found  = 1'b0;
    winner = gnt_id_q;
    cand   = gnt_id_q;
    for (int k = 1; k <= 4; k++) begin
      cand = gnt_id_q + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_l_d    = sel_l_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    hold_cnt_d = hold_cnt_q;
    if (!stall) begin
      if (hold_ok) begin
        gnt_vld_d = 1'b1;
        if (hold_cnt_q != CNT_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
      end else if (found) begin
        sel_l_d    = ~(4'b0001 << winner);
        gnt_id_d   = winner;
        gnt_vld_d  = 1'b1;
        hold_cnt_d = '0;
      end else begin
        // Idle: selects stay parked on the last grantee so the mux stays one-cold.
        gnt_vld_d  = 1'b0;
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      sel_l_q    <= 4'b1110;
      gnt_id_q   <= 2'd0;
      gnt_vld_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      sel_l_q    <= sel_l_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign sel0_l  = sel_l_q[0];
  assign sel1_l  = sel_l_q[1];
  assign sel2_l  = sel_l_q[2];
  assign sel3_l  = sel_l_q[3];
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_sparc_rr_sel4.sv
// Bench for sparc_rr_sel4: directed scenarios plus randomized traffic against
// a rule-level reference model, with one-cold and starvation monitors.
module tb_sparc_rr_sel4;

  localparam int MAX_HOLD = 4;
  localparam int CW       = 4;

  logic       rclk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       hold;
  logic       stall;
  logic       sel0_l, sel1_l, sel2_l, sel3_l;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic [3:0] sel_l;

  int errors = 0;
  int checks = 0;

  // Reference model state: last grantee, grant-live flag, hold length so far.
  int m_gid, m_vld, m_cnt;
  logic [6:0] exp_q[$];

  assign sel_l = {sel3_l, sel2_l, sel1_l, sel0_l};

  sparc_rr_sel4 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .rclk(rclk), .reset(reset), .req(req), .hold(hold), .stall(stall),
    .sel0_l(sel0_l), .sel1_l(sel1_l), .sel2_l(sel2_l), .sel3_l(sel3_l),
    .gnt_vld(gnt_vld), .gnt_id(gnt_id)
  );

  always #5 rclk = ~rclk;

  task automatic model_reset();
    m_gid = 0;
    m_vld = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int  others;
    bit  done;
    int  j;
    if (stall) return;
    others = 0;
    for (int i = 0; i < 4; i++) if (i != m_gid && req[i]) others = 1;
    if (m_vld != 0 && hold && req[m_gid] && (m_cnt < MAX_HOLD - 1 || others == 0)) begin
      m_cnt = (m_cnt + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_cnt + 1;
    end else if (req != 4'd0) begin
      done = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        j = (m_gid + k) % 4;
        if (!done && req[j]) begin
          m_gid = j;
          done  = 1'b1;
        end
      end
      m_vld = 1;
      m_cnt = 0;
    end else begin
      m_vld = 0;
      m_cnt = 0;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [3:0] s;
    s = 4'b1111 ^ (4'b0001 << m_gid);
    return {s, (m_vld != 0), 2'(m_gid)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge rclk);
    #1;
  endtask

  // Invariant monitors, sampled on the falling edge.
  logic [3:0] req_s = 4'd0;
  logic       stall_s = 1'b0;
  int         wait_cnt[4];

  always @(posedge rclk) begin
    req_s   <= req;
    stall_s <= stall;
  end

  always @(negedge rclk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end else begin
      checks++;
      if ($countones(~sel_l) != 1 || sel_l[gnt_id] !== 1'b0) begin
        errors++;
        $display("FAIL onecold t=%0t got sel_l=%b gnt_id=%0d, need one-cold low at gnt_id", $time, sel_l, gnt_id);
      end
      for (int i = 0; i < 4; i++) begin
        if (stall_s || !req_s[i] || (gnt_vld && gnt_id == 2'(i))) begin
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
          checks++;
          if (wait_cnt[i] > 3 * MAX_HOLD + 1) begin
            errors++;
            $display("FAIL starve t=%0t req%0d waited %0d cycles, limit %0d", $time, i, wait_cnt[i], 3 * MAX_HOLD + 1);
            wait_cnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; req = 4'd0; hold = 1'b0; stall = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_async got sel_l=%b vld=%b id=%0d need 1110/0/0", sel_l, gnt_vld, gnt_id);
    end
    @(posedge rclk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got sel_l=%b vld=%b id=%0d need 1110/0/0", c, sel_l, gnt_vld, gnt_id);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_sel;
    req = 4'b1000; hold = 1'b0;
    tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b0111, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL rot_setup got sel_l=%b vld=%b id=%0d need 0111/1/3", sel_l, gnt_vld, gnt_id);
    end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_sel = 4'b1111;
      exp_sel[c % 4] = 1'b0;
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== {exp_sel, 1'b1, 2'(c % 4)}) begin
        errors++;
        $display("FAIL rotation cyc=%0d got sel_l=%b vld=%b id=%0d need %b/1/%0d", c, sel_l, gnt_vld, gnt_id, exp_sel, c % 4);
      end
    end
  endtask

  task automatic test_hold_limit();
    int exp_id[9];
    exp_id = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    req = 4'b0011; hold = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_id !== 2'(exp_id[c])) begin
        errors++;
        $display("FAIL hold_limit cyc=%0d got vld=%b id=%0d need 1/%0d", c, gnt_vld, gnt_id, exp_id[c]);
      end
    end
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b1, 2'd0}) begin
        errors++;
        $display("FAIL hold_sole cyc=%0d got sel_l=%b vld=%b id=%0d need 1110/1/0", c, sel_l, gnt_vld, gnt_id);
      end
    end
  endtask

  task automatic test_stall();
    req = 4'b1111; hold = 1'b0;
    tick();
    tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1011, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL stall_setup got sel_l=%b vld=%b id=%0d need 1011/1/2", sel_l, gnt_vld, gnt_id);
    end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req  = 4'($urandom_range(0, 15));
      hold = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== {4'b1011, 1'b1, 2'd2}) begin
        errors++;
        $display("FAIL stall_freeze cyc=%0d got sel_l=%b vld=%b id=%0d need 1011/1/2", c, sel_l, gnt_vld, gnt_id);
      end
    end
    stall = 1'b0; req = 4'b1111; hold = 1'b0;
    tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b0111, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL stall_release got sel_l=%b vld=%b id=%0d need 0111/1/3", sel_l, gnt_vld, gnt_id);
    end
  endtask

  task automatic test_idle_retention();
    req = 4'b0000; hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== {4'b0111, 1'b0, 2'd3}) begin
        errors++;
        $display("FAIL idle_keep cyc=%0d got sel_l=%b vld=%b id=%0d need 0111/0/3", c, sel_l, gnt_vld, gnt_id);
      end
    end
    req = 4'b0101;
    tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL idle_wrap got sel_l=%b vld=%b id=%0d need 1110/1/0", sel_l, gnt_vld, gnt_id);
    end
  endtask

  task automatic test_async_reset_mid_hold();
    int exp_id[4];
    exp_id = '{1, 1, 1, 0};
    req = 4'b0010; hold = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1101, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL midhold_setup got sel_l=%b vld=%b id=%0d need 1101/1/1", sel_l, gnt_vld, gnt_id);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL midhold_reset got sel_l=%b vld=%b id=%0d need 1110/0/0", sel_l, gnt_vld, gnt_id);
    end
    @(posedge rclk); #1;
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1110, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL midhold_in_reset got sel_l=%b vld=%b id=%0d need 1110/0/0", sel_l, gnt_vld, gnt_id);
    end
    #2;
    reset = 1'b0;
    req = 4'b0010; hold = 1'b1;
    tick();
    checks++;
    if ({sel_l, gnt_vld, gnt_id} !== {4'b1101, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL midhold_regrant got sel_l=%b vld=%b id=%0d need 1101/1/1", sel_l, gnt_vld, gnt_id);
    end
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_id !== 2'(exp_id[c])) begin
        errors++;
        $display("FAIL midhold_cnt cyc=%0d got vld=%b id=%0d need 1/%0d", c, gnt_vld, gnt_id, exp_id[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      hold  = 1'($urandom_range(0, 1));
      stall = ($urandom_range(0, 7) == 0);
      model_step();
      exp_q.push_back(model_out());
      @(posedge rclk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({sel_l, gnt_vld, gnt_id} !== e) begin
        errors++;
        $display("FAIL random cyc=%0d got sel_l=%b vld=%b id=%0d need %b/%b/%0d", c, sel_l, gnt_vld, gnt_id, e[6:3], e[2], e[1:0]);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hold_limit();
    test_stall();
    test_idle_retention();
    test_async_reset_mid_hold();
    test_random();
    @(posedge rclk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
